chip8_sprite_draw: RTL and testbench

// - Executes the CHIP-8 DXYN sprite draw (lores 64x32, 1 bpp) as a sequencer upstream of chip8_memory.
// - Drives chip8_memory's video request port:
//   - reads N sprite bytes from RAM at I;
//   - read-modify-writes the XOR'd pixels into VRAM.
// - Reports the VF collision flag back to the processor.
// - One draw is in flight at a time; the processor stalls on busy_out.

---
 rtl/chip8_pkg.sv | 43 ++++
 rtl/chip8_sprite_draw_if.sv | 38 +++
 rtl/chip8_sprite_draw.sv | 208 ++++++++++++++++++++
 tb/tb_chip8_sprite_draw.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared CHIP-8 video definitions: memory-port types, screen geometry,
// draw-sequencer states and the sprite byte alignment helper.
package chip8_pkg;

    localparam logic VIDEO_MEM_TYPE_RAM  = 1'b0;
    localparam logic VIDEO_MEM_TYPE_VRAM = 1'b1;

    localparam int SCREEN_W       = 64;
    localparam int SCREEN_H       = 32;
    localparam int VRAM_ROW_BYTES = 8;

    typedef enum logic [3:0] {
        DRAW_IDLE,
        DRAW_FETCH,
        DRAW_FWAIT,
        DRAW_ROWCHK,
        DRAW_RDL,
        DRAW_WAITL,
        DRAW_WRL,
        DRAW_RDR,
        DRAW_WAITR,
        DRAW_WRR,
        DRAW_NEXT,
        DRAW_DONE
    } draw_state_e;

    typedef struct packed {
        logic [7:0] left;
        logic [7:0] right;
    } align_t;

    // A sprite row straddles at most two VRAM bytes; split it by bit offset.
    function automatic align_t sprite_align(
        input logic [7:0] spr,
        input logic [2:0] sh
    );
        align_t a;
        a.left  = spr >> sh;
        a.right = (sh == 3'd0) ? 8'h00 : (spr << (4'd8 - {1'b0, sh}));
        return a;
    endfunction

endpackage

// File: rtl/chip8_sprite_draw_if.sv
// Video request port between the sprite sequencer and chip8_memory.
interface chip8_sprite_draw_if;

    logic [15:0] mem_addr_out;
    logic        mem_we_out;
    logic        mem_valid_out;
    logic [15:0] mem_data_out;
    logic        mem_type_out;
    logic        mem_size_out;
    logic        mem_ready_in;
    logic        mem_valid_in;
    logic [15:0] mem_data_in;

    modport master (
        output mem_addr_out,
        output mem_we_out,
        output mem_valid_out,
        output mem_data_out,
        output mem_type_out,
        output mem_size_out,
        input  mem_ready_in,
        input  mem_valid_in,
        input  mem_data_in
    );

    modport slave (
        input  mem_addr_out,
        input  mem_we_out,
        input  mem_valid_out,
        input  mem_data_out,
        input  mem_type_out,
        input  mem_size_out,
        output mem_ready_in,
        output mem_valid_in,
        output mem_data_in
    );

endinterface

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sequencer: fetches sprite rows from RAM and XORs them into
// lores VRAM with read-modify-write, accumulating the VF collision flag.
module chip8_sprite_draw
    import chip8_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter bit CLIP  = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] i_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        collision_out,
    chip8_sprite_draw_if.master mem
);

    draw_state_e      state_q;
    logic [5:0]       x0_q;
    logic [4:0]       y0_q;
    logic [4:0]       row_q;
    logic [3:0]       n_q;
    logic [3:0]       r_q;
    logic [11:0]      i_q;
    logic [WIDTH-1:0] spr_q;
    logic             coll_q;
    logic             req_q;
    logic             busy_q;
    logic             done_q;
    logic             coll_out_q;
    logic             we_q;
    logic             type_q;
    logic [15:0]      addr_q;
    logic [15:0]      data_q;

    align_t           al;
    logic [5:0]       row_d;
    logic [3:0]       r_d;
    logic [2:0]       xb_r;
    logic [7:0]       addr_l;
    logic [7:0]       addr_r;
    logic             skip_r;
    logic             fire;
    logic [WIDTH-1:0] rd_byte;
    logic             unused_w;

    assign al      = sprite_align(spr_q, x0_q[2:0]);
    assign row_d   = {1'b0, y0_q} + {2'b00, r_q};
    assign r_d     = r_q + 4'd1;
    assign xb_r    = x0_q[5:3] + 3'd1;
    assign addr_l  = {row_q, x0_q[5:3]};
    assign addr_r  = {row_q, xb_r};
    assign skip_r  = (al.right == 8'h00) || (CLIP && (x0_q[5:3] == 3'd7));
    assign fire    = req_q & mem.mem_ready_in;
    assign rd_byte = mem.mem_data_in[WIDTH-1:0];
    assign unused_w = ^{mem.mem_data_in[15:WIDTH], x_in[7:6], y_in[7:5]};

    assign busy_out          = busy_q;
    assign done_out          = done_q;
    assign collision_out     = coll_out_q;
    assign mem.mem_addr_out  = addr_q;
    assign mem.mem_we_out    = we_q;
    assign mem.mem_valid_out = fire;
    assign mem.mem_data_out  = data_q;
    assign mem.mem_type_out  = type_q;
    assign mem.mem_size_out  = 1'b0;

    // req_q marks a pending request; the strobe is only let out while ready.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= DRAW_IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            row_q      <= '0;
            n_q        <= '0;
            r_q        <= '0;
            i_q        <= '0;
            spr_q      <= '0;
            coll_q     <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            coll_out_q <= 1'b0;
            we_q       <= 1'b0;
            type_q     <= VIDEO_MEM_TYPE_RAM;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            unique case (state_q)
                DRAW_IDLE: if (start_in) begin
                    x0_q       <= x_in[5:0];
                    y0_q       <= y_in[4:0];
                    n_q        <= n_in;
                    i_q        <= i_in;
                    r_q        <= '0;
                    coll_q     <= 1'b0;
                    coll_out_q <= 1'b0;
                    busy_q     <= 1'b1;
                    if (n_in == 4'd0) begin
                        done_q  <= 1'b1;
                        state_q <= DRAW_DONE;
                    end else begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        type_q  <= VIDEO_MEM_TYPE_RAM;
                        addr_q  <= {4'h0, i_in};
                        data_q  <= '0;
                        state_q <= DRAW_FETCH;
                    end
                end
                DRAW_FETCH: if (fire) begin
                    req_q   <= 1'b0;
                    state_q <= DRAW_FWAIT;
                end
                DRAW_FWAIT: if (mem.mem_valid_in) begin
                    spr_q   <= rd_byte;
                    state_q <= DRAW_ROWCHK;
                end
                DRAW_ROWCHK: begin
                    if (CLIP && (row_d >= 6'(SCREEN_H))) begin
                        state_q <= DRAW_NEXT;
                    end else begin
                        row_q   <= row_d[4:0];
                        state_q <= DRAW_RDL;
                    end
                end
                DRAW_RDL: begin
                    if (al.left == 8'h00) begin
                        state_q <= DRAW_RDR;
                    end else if (!req_q) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        type_q <= VIDEO_MEM_TYPE_VRAM;
                        addr_q <= {8'h00, addr_l};
                        data_q <= '0;
                    end else if (mem.mem_ready_in) begin
                        req_q   <= 1'b0;
                        state_q <= DRAW_WAITL;
                    end
                end
                DRAW_WAITL: if (mem.mem_valid_in) begin
                    coll_q  <= coll_q | (|(rd_byte & al.left));
                    data_q  <= 16'(rd_byte ^ al.left);
                    we_q    <= 1'b1;
                    req_q   <= 1'b1;
                    state_q <= DRAW_WRL;
                end
                DRAW_WRL: if (fire) begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= DRAW_RDR;
                end
                DRAW_RDR: begin
                    if (skip_r) begin
                        state_q <= DRAW_NEXT;
                    end else if (!req_q) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        type_q <= VIDEO_MEM_TYPE_VRAM;
                        addr_q <= {8'h00, addr_r};
                        data_q <= '0;
                    end else if (mem.mem_ready_in) begin
                        req_q   <= 1'b0;
                        state_q <= DRAW_WAITR;
                    end
                end
                DRAW_WAITR: if (mem.mem_valid_in) begin
                    coll_q  <= coll_q | (|(rd_byte & al.right));
                    data_q  <= 16'(rd_byte ^ al.right);
                    we_q    <= 1'b1;
                    req_q   <= 1'b1;
                    state_q <= DRAW_WRR;
                end
                DRAW_WRR: if (fire) begin
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    state_q <= DRAW_NEXT;
                end
                DRAW_NEXT: begin
                    r_q <= r_d;
                    if (r_d == n_q) begin
                        done_q     <= 1'b1;
                        coll_out_q <= coll_q;
                        state_q    <= DRAW_DONE;
                    end else begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b0;
                        type_q  <= VIDEO_MEM_TYPE_RAM;
                        addr_q  <= {4'h0, i_q + 12'(r_d)};
                        data_q  <= '0;
                        state_q <= DRAW_FETCH;
                    end
                end
                DRAW_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= DRAW_IDLE;
                end
                default: state_q <= DRAW_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Self-checking bench: a clipping and a wrapping sequencer share one
// stalling memory model; results are compared to a pixel-level reference.
module tb_chip8_sprite_draw;
    import chip8_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_c = 1'b0;
    logic        start_w = 1'b0;
    logic [7:0]  x_in = '0;
    logic [7:0]  y_in = '0;
    logic [3:0]  n_in = '0;
    logic [11:0] i_in = '0;
    logic        busy_c, done_c, coll_c;
    logic        busy_w, done_w, coll_w;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chip8_sprite_draw_if bus_c ();
    chip8_sprite_draw_if bus_w ();

    chip8_sprite_draw #(.WIDTH(8), .CLIP(1'b1)) u_clip (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_c),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
        .busy_out(busy_c), .done_out(done_c), .collision_out(coll_c),
        .mem(bus_c.master)
    );

    chip8_sprite_draw #(.WIDTH(8), .CLIP(1'b0)) u_wrap (
        .clk_in(clk), .rst_in(rst_n), .start_in(start_w),
        .x_in(x_in), .y_in(y_in), .n_in(n_in), .i_in(i_in),
        .busy_out(busy_w), .done_out(done_w), .collision_out(coll_w),
        .mem(bus_w.master)
    );

    // sel=0 routes the memory to the clipping unit, sel=1 to the wrapping one
    logic        sel = 1'b0;
    logic        rdy = 1'b1;
    int          stall = 0;
    logic        pend = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_dat = '0;
    logic        m_vld = 1'b0;
    logic [15:0] m_dat = '0;
    int          ram_rd = 0;
    int          vram_rd = 0;
    int          vram_wr = 0;
    int          viol = 0;
    logic [7:0]  ram [4096];
    logic [7:0]  vram [256] = '{default: 8'h00};
    logic [7:0]  vexp [256];
    logic [15:0] rlog [1024];

    logic        b_valid, b_we, b_type, b_size, b_other;
    logic [15:0] b_addr, b_data;
    logic        busy_s, done_s, coll_s;

    always_comb begin
        if (sel) begin
            b_valid = bus_w.mem_valid_out;
            b_we    = bus_w.mem_we_out;
            b_type  = bus_w.mem_type_out;
            b_size  = bus_w.mem_size_out;
            b_addr  = bus_w.mem_addr_out;
            b_data  = bus_w.mem_data_out;
            b_other = bus_c.mem_valid_out;
        end else begin
            b_valid = bus_c.mem_valid_out;
            b_we    = bus_c.mem_we_out;
            b_type  = bus_c.mem_type_out;
            b_size  = bus_c.mem_size_out;
            b_addr  = bus_c.mem_addr_out;
            b_data  = bus_c.mem_data_out;
            b_other = bus_w.mem_valid_out;
        end
    end

    assign bus_c.mem_ready_in = rdy & ~sel;
    assign bus_c.mem_valid_in = m_vld & ~sel;
    assign bus_c.mem_data_in  = m_dat;
    assign bus_w.mem_ready_in = rdy & sel;
    assign bus_w.mem_valid_in = m_vld & sel;
    assign bus_w.mem_data_in  = m_dat;
    assign busy_s = sel ? busy_w : busy_c;
    assign done_s = sel ? done_w : done_c;
    assign coll_s = sel ? coll_w : coll_c;

    always @(posedge clk) begin
        int s;
        m_vld <= 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                m_vld <= 1'b1;
                m_dat <= pend_dat;
                pend  <= 1'b0;
            end else begin
                pend_cnt <= pend_cnt - 1;
            end
        end
        if (stall > 0) begin
            rdy   <= 1'b0;
            stall <= stall - 1;
        end else begin
            rdy <= 1'b1;
        end
        if (b_other || (b_valid && (!rdy || b_size
                || (b_we && (b_type != VIDEO_MEM_TYPE_VRAM || b_data[15:8] != 8'h00))
                || (b_type == VIDEO_MEM_TYPE_VRAM && b_addr[15:8] != 8'h00)
                || (b_type == VIDEO_MEM_TYPE_RAM && b_addr[15:12] != 4'h0))))
            viol <= viol + 1;
        if (b_valid) begin
            s = int'($urandom_range(0, 3));
            stall <= (s > 0) ? s - 1 : 0;
            rdy   <= (s == 0);
            if (b_we) begin
                if (b_type == VIDEO_MEM_TYPE_VRAM) begin
                    vram[b_addr[7:0]] <= b_data[7:0];
                    vram_wr <= vram_wr + 1;
                end
            end else begin
                pend     <= 1'b1;
                pend_cnt <= int'($urandom_range(0, 3));
                if (b_type == VIDEO_MEM_TYPE_VRAM) begin
                    pend_dat <= {8'h00, vram[b_addr[7:0]]};
                    vram_rd  <= vram_rd + 1;
                end else begin
                    pend_dat <= {8'h00, ram[b_addr[11:0]]};
                    rlog[ram_rd[9:0]] <= b_addr;
                    ram_rd   <= ram_rd + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel-by-pixel XOR on the expected screen; nb = VRAM bytes touched.
    task automatic model_draw(input bit s, input logic [7:0] x, input logic [7:0] y,
                              input logic [3:0] n, input logic [11:0] i,
                              output bit coll, output int nb);
        int x0, y0, py, px, idx;
        logic [7:0] spr, m;
        bit [7:0] touched;
        x0 = int'(x) % 64;
        y0 = int'(y) % 32;
        coll = 1'b0;
        nb = 0;
        for (int r = 0; r < int'(n); r++) begin
            spr = ram[(int'(i) + r) % 4096];
            touched = '0;
            py = y0 + r;
            if (py >= 32 && !s) continue;
            py = py % 32;
            for (int b = 0; b < 8; b++) begin
                if (!spr[7 - b]) continue;
                px = x0 + b;
                if (px >= 64 && !s) continue;
                px = px % 64;
                idx = py * 8 + px / 8;
                m = 8'h80 >> (px % 8);
                if ((vexp[idx] & m) != 8'h00) coll = 1'b1;
                vexp[idx] = vexp[idx] ^ m;
                touched[px / 8] = 1'b1;
            end
            nb += $countones(touched);
        end
    endtask

    task automatic run_draw(input bit s, input logic [7:0] x, input logic [7:0] y,
                            input logic [3:0] n, input logic [11:0] i,
                            input bit restart, input string tag);
        bit ecoll, got;
        int nb, rr0, vr0, wr0, cyc, diffs;
        model_draw(s, x, y, n, i, ecoll, nb);
        @(negedge clk);
        sel = s;
        rr0 = ram_rd;
        vr0 = vram_rd;
        wr0 = vram_wr;
        x_in = x;
        y_in = y;
        n_in = n;
        i_in = i;
        if (s) start_w = 1'b1; else start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        start_w = 1'b0;
        chk({tag, "_busy"}, busy_s, 1'b1);
        chk({tag, "_done1"}, done_s, n == 4'd0);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 3000) begin
            if (done_s) begin
                got = 1'b1;
            end else begin
                if (restart && cyc == 2) begin
                    x_in = ~x;
                    y_in = ~y;
                    n_in = n + 4'd1;
                    i_in = i + 12'h5;
                    if (s) start_w = 1'b1; else start_c = 1'b1;
                end
                if (restart && cyc == 3) begin
                    start_c = 1'b0;
                    start_w = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        start_c = 1'b0;
        start_w = 1'b0;
        chk({tag, "_done"}, got, 1'b1);
        chk({tag, "_coll"}, coll_s, ecoll);
        @(negedge clk);
        chk({tag, "_idle"}, {busy_s, done_s}, 2'b00);
        chk({tag, "_hold"}, coll_s, ecoll);
        repeat (4) @(negedge clk);
        diffs = 0;
        for (int a = 0; a < 256; a++) if (vram[a] !== vexp[a]) diffs++;
        chk({tag, "_vram"}, diffs, 0);
        chk({tag, "_ramrd"}, ram_rd - rr0, n);
        chk({tag, "_vrd"}, vram_rd - vr0, nb);
        chk({tag, "_vwr"}, vram_wr - wr0, nb);
        chk({tag, "_proto"}, viol, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, {busy_c, busy_w}, 2'b00);
        chk({tag, "_done"}, {done_c, done_w}, 2'b00);
        chk({tag, "_coll"}, {coll_c, coll_w}, 2'b00);
        chk({tag, "_valid"}, {bus_c.mem_valid_out, bus_w.mem_valid_out}, 2'b00);
        chk({tag, "_we"}, {bus_c.mem_we_out, bus_w.mem_we_out}, 2'b00);
        chk({tag, "_addr"}, {bus_c.mem_addr_out, bus_w.mem_addr_out}, 32'h0);
        chk({tag, "_data"}, {bus_c.mem_data_out, bus_w.mem_data_out}, 32'h0);
    endtask

    initial begin
        int rb, cyc;
        bit rs;
        logic [7:0] rx, ry;
        logic [3:0] rn;
        logic [11:0] ri;
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
        for (int a = 0; a < 256; a++) vexp[a] = 8'h00;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        ram[12'h200] = 8'hF0;
        run_draw(1'b0, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, "s1a");
        chk("s1a_v0", vram[0], 8'hF0);
        chk("s1a_c", coll_c, 1'b0);
        run_draw(1'b0, 8'd0, 8'd0, 4'd1, 12'h200, 1'b0, "s1b");
        chk("s1b_v0", vram[0], 8'h00);
        chk("s1b_c", coll_c, 1'b1);

        ram[12'h300] = 8'hFF;
        run_draw(1'b0, 8'd3, 8'd2, 4'd1, 12'h300, 1'b0, "s2");
        chk("s2_v16", vram[16], 8'h1F);
        chk("s2_v17", vram[17], 8'hE0);

        ram[12'h200] = 8'hFF;
        ram[12'h201] = 8'hFF;
        run_draw(1'b0, 8'd60, 8'd31, 4'd2, 12'h200, 1'b0, "s3c");
        chk("s3c_v255", vram[255], 8'h0F);
        chk("s3c_v248", vram[248], 8'h00);
        run_draw(1'b1, 8'd60, 8'd31, 4'd2, 12'h200, 1'b0, "s3w");
        chk("s3w_v255", vram[255], 8'h00);
        chk("s3w_v248", vram[248], 8'hF0);
        chk("s3w_v7", vram[7], 8'h0F);
        chk("s3w_v0", vram[0], 8'hF0);

        ram[12'h210] = 8'h80;
        run_draw(1'b0, 8'd70, 8'd40, 4'd1, 12'h210, 1'b0, "s4");
        chk("s4_v64", vram[64], 8'h02);
        run_draw(1'b0, 8'd5, 8'd5, 4'd0, 12'h123, 1'b0, "s4n0");

        ram[12'hFFF] = 8'hAA;
        ram[12'h000] = 8'h55;
        rb = ram_rd;
        run_draw(1'b0, 8'd16, 8'd10, 4'd2, 12'hFFF, 1'b1, "s5");
        chk("s5_a0", rlog[rb % 1024], 16'h0FFF);
        chk("s5_a1", rlog[(rb + 1) % 1024], 16'h0000);

        @(negedge clk);
        sel = 1'b0;
        ram[12'h400] = 8'hFF;
        x_in = 8'd8;
        y_in = 8'd5;
        n_in = 4'd1;
        i_in = 12'h400;
        rb = vram_rd;
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        cyc = 0;
        while (vram_rd == rb && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("s6_rdseen", vram_rd != rb, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_reset("s6_rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("s6_quiet", {busy_c, done_c}, 2'b00);
        chk("s6_v41", vram[41], vexp[41]);
        run_draw(1'b0, 8'd8, 8'd5, 4'd1, 12'h400, 1'b0, "s6b");

        for (int k = 0; k < 30; k++) begin
            rs = 1'($urandom_range(0, 1));
            rx = 8'($urandom);
            ry = 8'($urandom);
            rn = 4'($urandom_range(0, 15));
            ri = 12'($urandom);
            run_draw(rs, rx, ry, rn, ri, (rn != 4'd0) && ($urandom_range(0, 1) == 1), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
